// File: rtl/sctag_rdmat_pkg.sv
// Shared types and helpers for the RDMA write-buffer (WIB) allocation controller.
// Entry states, index type and the round-robin pick used by the arbiter.
package sctag_rdmat_pkg;

    localparam int NUM_ENT = 4;
    localparam int ENT_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_PEND   = 2'd2,
        ST_INPIPE = 2'd3
    } ent_state_e;

    typedef logic [ENT_W-1:0] ent_idx_t;

    // Returns the first candidate found starting at ptr+1 (wrapping); 0 if none.
    function automatic ent_idx_t rr_pick(input logic [NUM_ENT-1:0] cand, input ent_idx_t ptr);
        ent_idx_t idx;
        ent_idx_t pick;
        logic     found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_ENT; k++) begin
            idx = ptr + ent_idx_t'(k);
            if (!found && cand[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sctag_rdmat_ctl_if.sv
// Bus between the JBI/pipe side (master) and the WIB allocation controller (slave).
interface sctag_rdmat_ctl_if;
    import sctag_rdmat_pkg::*;

    // Request/grant: snp_winv_alloc_s1 is a request with no ready; the controller
    // answers in the same cycle with rdmat_alloc_vld_s1 plus rdmat_wr_entry_s1.
    // A request that is not granted is dropped (and flagged on rdmat_err).
    logic       snp_winv_alloc_s1;
    logic       snp_fill_done_s17;
    logic       arbctl_rdma_issue_c2;
    ent_idx_t   arbctl_rdma_issue_entry_c2;
    logic       rdma_release_vld;
    ent_idx_t   rdma_release_entry;
    ent_idx_t   rdmat_wr_entry_s1;
    logic       rdmat_alloc_vld_s1;
    logic [3:0] rdmat_vld;
    logic       rdmat_full;
    logic       rdmat_fill_active;
    logic       sctag_jbi_wib_dequeue;
    logic       rdmat_err;

    modport master (
        output snp_winv_alloc_s1, snp_fill_done_s17, arbctl_rdma_issue_c2,
               arbctl_rdma_issue_entry_c2, rdma_release_vld, rdma_release_entry,
        input  rdmat_wr_entry_s1, rdmat_alloc_vld_s1, rdmat_vld, rdmat_full,
               rdmat_fill_active, sctag_jbi_wib_dequeue, rdmat_err
    );

    modport slave (
        input  snp_winv_alloc_s1, snp_fill_done_s17, arbctl_rdma_issue_c2,
               arbctl_rdma_issue_entry_c2, rdma_release_vld, rdma_release_entry,
        output rdmat_wr_entry_s1, rdmat_alloc_vld_s1, rdmat_vld, rdmat_full,
               rdmat_fill_active, sctag_jbi_wib_dequeue, rdmat_err
    );

endinterface

// File: rtl/sctag_rdmat_ent.sv
// Lifecycle FSM of one WIB entry: IDLE -> FILL -> PEND -> INPIPE -> IDLE.
// Exposes current and next state; err flags an event that does not match the state.
module sctag_rdmat_ent
    import sctag_rdmat_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       grant,
    input  logic       fill_done_hit,
    input  logic       issue_hit,
    input  logic       release_hit,
    output ent_state_e state,
    output ent_state_e state_nxt,
    output logic       err
);

    ent_state_e state_q;
    ent_state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant)         state_d = ST_FILL;
            ST_FILL:   if (fill_done_hit) state_d = ST_PEND;
            ST_PEND:   if (issue_hit)     state_d = ST_INPIPE;
            ST_INPIPE: if (release_hit)   state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state     = state_q;
        state_nxt = state_d;
        err       = (grant         && (state_q != ST_IDLE))
                  | (fill_done_hit && (state_q != ST_FILL))
                  | (issue_hit     && (state_q != ST_PEND))
                  | (release_hit   && (state_q != ST_INPIPE));
    end

endmodule

// File: rtl/sctag_rdmat_ctl.sv
// WIB allocation controller: round-robin grant of IDLE entries, single-fill tracking,
// per-entry lifecycle, dequeue credit to JBI and a sticky protocol-error flag.
module sctag_rdmat_ctl
    import sctag_rdmat_pkg::*;
(
    input  logic rclk,
    input  logic rst,
    input  logic se,
    input  logic si,
    output logic so,
    sctag_rdmat_ctl_if.slave bus
);

    ent_state_e         ent_state     [NUM_ENT];
    ent_state_e         ent_state_nxt [NUM_ENT];
    logic [NUM_ENT-1:0] ent_err;
    logic [NUM_ENT-1:0] idle_vec;
    logic [NUM_ENT-1:0] fill_vec;
    logic [NUM_ENT-1:0] grant_vec;
    logic [NUM_ENT-1:0] fd_hit;
    logic [NUM_ENT-1:0] iss_hit;
    logic [NUM_ENT-1:0] rel_hit;
    logic               fill_active;
    logic               alloc_ok;
    ent_idx_t           pick;

    ent_idx_t           rr_ptr_q, rr_ptr_d;
    ent_idx_t           fill_entry_q, fill_entry_d;
    logic [NUM_ENT-1:0] vld_q, vld_d;
    logic               full_q, full_d;
    logic               deq_q, deq_d;
    logic               err_q, err_d;
    logic               so_q, so_d;

    for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
        sctag_rdmat_ent u_ent (
            .clk           (rclk),
            .rst           (rst),
            .grant         (grant_vec[i]),
            .fill_done_hit (fd_hit[i]),
            .issue_hit     (iss_hit[i]),
            .release_hit   (rel_hit[i]),
            .state         (ent_state[i]),
            .state_nxt     (ent_state_nxt[i]),
            .err           (ent_err[i])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            idle_vec[i] = (ent_state[i] == ST_IDLE);
            fill_vec[i] = (ent_state[i] == ST_FILL);
            vld_d[i]    = (ent_state_nxt[i] != ST_IDLE);
        end
        fill_active = |fill_vec;
        pick        = rr_pick(idle_vec, rr_ptr_q);
        // Grant sees pre-edge state, so an entry released this cycle is not yet a candidate.
        alloc_ok    = bus.snp_winv_alloc_s1 && !fill_active && (|idle_vec);
        for (int i = 0; i < NUM_ENT; i++) begin
            grant_vec[i] = alloc_ok && (pick == ent_idx_t'(i));
            fd_hit[i]    = bus.snp_fill_done_s17 && fill_active && (fill_entry_q == ent_idx_t'(i));
            iss_hit[i]   = bus.arbctl_rdma_issue_c2 && (bus.arbctl_rdma_issue_entry_c2 == ent_idx_t'(i));
            rel_hit[i]   = bus.rdma_release_vld && (bus.rdma_release_entry == ent_idx_t'(i));
        end
        rr_ptr_d     = alloc_ok ? pick : rr_ptr_q;
        fill_entry_d = alloc_ok ? pick : fill_entry_q;
        full_d       = &vld_d;
        deq_d        = bus.rdma_release_vld && (ent_state[bus.rdma_release_entry] == ST_INPIPE);
        err_d        = err_q
                     | (bus.snp_winv_alloc_s1 && !alloc_ok)
                     | (bus.snp_fill_done_s17 && !fill_active)
                     | (|ent_err);
        so_d         = se ? si : so_q;
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            rr_ptr_q     <= ent_idx_t'(NUM_ENT - 1);
            fill_entry_q <= '0;
            vld_q        <= '0;
            full_q       <= 1'b0;
            deq_q        <= 1'b0;
            err_q        <= 1'b0;
            so_q         <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            fill_entry_q <= fill_entry_d;
            vld_q        <= vld_d;
            full_q       <= full_d;
            deq_q        <= deq_d;
            err_q        <= err_d;
            so_q         <= so_d;
        end
    end

    always_comb begin
        bus.rdmat_alloc_vld_s1    = alloc_ok;
        bus.rdmat_wr_entry_s1     = alloc_ok ? pick : '0;
        bus.rdmat_vld             = vld_q;
        bus.rdmat_full            = full_q;
        bus.rdmat_fill_active     = fill_active;
        bus.sctag_jbi_wib_dequeue = deq_q;
        bus.rdmat_err             = err_q;
        so                        = so_q;
    end

endmodule

// File: doc/sctag_rdmat_ctl.md
Name: sctag_rdmat_ctl

Overview:
Allocation controller for the 4-entry RDMA write buffer (WIB) that holds 64-byte write-invalidate (WR64) data from JBI. It grants a free entry in S1 of each WR64 header and drives the entry index to the snoop-IQ control and scbuf write-wordline path. It tracks each entry through fill, pending-issue and in-pipe phases, and returns a dequeue credit to JBI when an entry is released.

Parameters:
NUM_ENT, 4, number of WIB entries (fixed at 4; index width 2)
FILL_BEATS, 16, data beats per WR64 fill (S2..S17)

Ports:
rclk  in  1  clock
rst  in  1  reset, synchronous, active-high
se  in  1  scan enable
si  in  1  scan in
so  out  1  scan out
snp_winv_alloc_s1  in  1  WR64 header2 cycle; requests an entry
snp_fill_done_s17  in  1  last WR64 data beat written this cycle
arbctl_rdma_issue_c2  in  1  WR64 instruction issued into the pipe
arbctl_rdma_issue_entry_c2  in  2  entry referenced by the issue
rdma_release_vld  in  1  entry data fully consumed
rdma_release_entry  in  2  entry being released
rdmat_wr_entry_s1  out  2  granted entry (combinational, valid with alloc_vld)
rdmat_alloc_vld_s1  out  1  grant made this cycle
rdmat_vld  out  4  per-entry non-IDLE
rdmat_full  out  1  all entries non-IDLE (registered)
rdmat_fill_active  out  1  an entry is in FILL
sctag_jbi_wib_dequeue  out  1  one-cycle credit pulse to JBI
rdmat_err  out  1  sticky protocol-error flag

Behaviour:
- Per-entry 2-bit state: IDLE=0, FILL=1, PEND=2, INPIPE=3.
- Allowed transitions:
  - IDLE->FILL on grant.
  - FILL->PEND on snp_fill_done_s17.
  - PEND->INPIPE on issue with a matching entry.
  - INPIPE->IDLE on release with a matching entry.
  - All other cases hold state.
- Grant:
  - Round-robin over IDLE entries, starting at rr_ptr+1 (mod 4). Lowest index wins after the rotation.
  - rr_ptr updates to the granted entry on the following edge.
  - rdmat_wr_entry_s1 = chosen index. It is 0 when there is no grant.
- Only one FILL at a time. fill_entry register holds the entry in FILL.
  - snp_fill_done_s17 moves fill_entry to PEND.
  - snp_winv_alloc_s1 while rdmat_fill_active=1 gives no grant and sets rdmat_err.
- Alloc while no entry is IDLE: no grant, rdmat_alloc_vld_s1=0, rdmat_err set, states unchanged.
- Release of an entry not in INPIPE: ignored, rdmat_err set.
- Issue of an entry not in PEND: ignored, rdmat_err set.
- fill_done with no FILL entry: ignored, rdmat_err set.
- Release and grant in the same cycle:
  - An entry released this cycle is not grantable until the next cycle (no bypass); grant uses the pre-edge state.
  - Release and grant of different entries both take effect.
- sctag_jbi_wib_dequeue is registered: it pulses 1 cycle after each valid release (1 pulse per release).
- rdmat_full and rdmat_vld are registered from next-state; latency 1 cycle after the event edge.
- rst (sync, active-high) at the next rclk edge:
  - All entries IDLE, rr_ptr=3 (first grant is entry 0), fill_entry=0.
  - rdmat_vld=0, rdmat_full=0, rdmat_fill_active=0, sctag_jbi_wib_dequeue=0, rdmat_err=0, rdmat_alloc_vld_s1=0.
  - rst has priority over every other input. Asserting it mid-fill drops the fill; the dequeue pulse already scheduled is suppressed.
- rdmat_err is cleared only by rst.

Decomposition:
- Package sctag_rdmat_pkg: state encodings (IDLE/FILL/PEND/INPIPE), NUM_ENT, entry-index width, rr priority function.
- Sub-module sctag_rdmat_ent: one per-entry state machine, instantiated 4 times. Inputs: grant, fill_done_hit, issue_hit, release_hit. Outputs: state and error contribution.
- Top holds the round-robin arbiter, fill_entry, rr_ptr, credit flop and err flop.

Test Plan:
- Reset, then 4 WR64 allocs spaced 20 cycles apart, each with fill_done 16 cycles after grant -> grants 0,1,2,3; rdmat_vld=4'b1111; rdmat_full=1 one cycle after the 4th grant.
- Full, then alloc -> rdmat_alloc_vld_s1=0, rdmat_err=1, rdmat_vld unchanged.
- Entry 2 in INPIPE, release entry 2 and alloc in the same cycle with entry 2 as the only other candidate -> no grant that cycle. Next alloc grants 2; dequeue pulses exactly once, one cycle after the release.
- Issue entry 1 while it is in FILL -> state stays FILL, rdmat_err=1. fill_done then issue entry 1 -> INPIPE.
- Round-robin: entries 0 and 3 IDLE, rr_ptr=0 -> grant 3; the next alloc grants 0.
- rst asserted 8 cycles into a fill with a release pending -> next cycle all outputs 0. No dequeue pulse. First grant after reset is entry 0.
